// File: rtl/seg7_scan_display_if.sv
`default_nettype none
// =============================================================================
// seg7_scan_display_if : display-word input and scanned-digit output bundle
// Rev 1.0
// =============================================================================
interface seg7_scan_display_if;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        load;
  logic        blank;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic        frame;

  modport master (
    output data, dp, load, blank,
    input  which, seg, frame
  );

  modport slave (
    input  data, dp, load, blank,
    output which, seg, frame
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// =============================================================================
// seg7_scan_display : time-multiplexed 8-digit hex seven-segment scanner
// Rev 1.0
// =============================================================================
module seg7_scan_display #(
  parameter int SCAN_DIV       = 12500,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_display_if.slave bus
);

  localparam int                 c_pre_w   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(SCAN_DIV - 1);
  localparam logic [7:0]         c_seg_rst = SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;

  logic [c_pre_w-1:0] r_pre;
  logic [2:0]         r_which;
  logic [31:0]        r_shadow;
  logic [7:0]         r_seg;
  logic               r_frame;

  logic               w_tick;
  logic [c_pre_w-1:0] w_pre_nxt;
  logic [2:0]         w_which_nxt;
  logic [31:0]        w_shadow_nxt;
  logic               w_frame_nxt;
  logic [7:0]         w_zero_from;
  logic [3:0]         w_nib;
  logic [7:0]         w_seg_hi;
  logic [7:0]         w_seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign w_tick       = (r_pre == c_pre_max);
  assign w_pre_nxt    = w_tick ? '0 : r_pre + 1'b1;
  assign w_which_nxt  = w_tick ? r_which + 3'd1 : r_which;
  assign w_shadow_nxt = bus.load ? bus.data : r_shadow;
  assign w_frame_nxt  = w_tick && (r_which == 3'd7);

  // Segments are encoded from the next which/shadow so the registered seg
  // always lines up with the registered which/shadow it is presented with.
  for (genvar gi = 0; gi < 8; gi++) begin : g_zero_from
    assign w_zero_from[gi] = ((w_shadow_nxt >> (4 * gi)) == 32'd0);
  end

  always_comb begin
    w_nib    = w_shadow_nxt[{w_which_nxt, 2'b00} +: 4];
    w_seg_hi = {bus.dp[w_which_nxt], hex7(w_nib)};
    if (BLANK_LZ && (w_which_nxt != 3'd0) && w_zero_from[w_which_nxt]) begin
      w_seg_hi[6:0] = 7'h00;
    end
    if (bus.blank) begin
      w_seg_hi = 8'h00;
    end
    w_seg_nxt = SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_which  <= 3'd0;
      r_shadow <= 32'd0;
      r_frame  <= 1'b0;
      r_seg    <= c_seg_rst;
    end else begin
      r_pre    <= w_pre_nxt;
      r_which  <= w_which_nxt;
      r_shadow <= w_shadow_nxt;
      r_frame  <= w_frame_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

  assign bus.which = r_which;
  assign bus.seg   = r_seg;
  assign bus.frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// =============================================================================
// tb_seg7_scan_display : scoreboard bench, expectations keyed by clock cycle
// Rev 1.0
// =============================================================================
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        load;
  logic        blank;

  seg7_scan_display_if bus0 ();
  seg7_scan_display_if bus1 ();

  assign bus0.data  = data;
  assign bus0.dp    = dp;
  assign bus0.load  = load;
  assign bus0.blank = blank;
  assign bus1.data  = data;
  assign bus1.dp    = dp;
  assign bus1.load  = load;
  assign bus1.blank = blank;

  seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_nlz (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    bit         nlz;
    logic [2:0] which;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   r_base = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  localparam logic [63:0] c_tab_89ab = 64'h80908883C6A1868E;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due at this cycle against the DUT.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [2:0] a_which;
    logic [7:0] a_seg;
    logic       a_frame;
    while (q.size() > 0 && (q[0].cyc <= cyc || done)) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)", e.name, e.cyc, cyc);
      end else begin
        a_which = e.nlz ? bus1.which : bus0.which;
        a_seg   = e.nlz ? bus1.seg   : bus0.seg;
        a_frame = e.nlz ? bus1.frame : bus0.frame;
        if (a_which !== e.which || a_seg !== e.seg || a_frame !== e.frame) begin
          failures++;
          $display("FAIL %s cyc=%0d: got which=%0d seg=%02h frame=%b, expected which=%0d seg=%02h frame=%b",
                   e.name, cyc, a_which, a_seg, a_frame, e.which, e.seg, e.frame);
        end
      end
    end
  end

  task automatic push1(input string nm, input int kk, input bit nlz,
                       input logic [2:0] w, input logic [7:0] s, input logic f);
    exp_t e;
    e.cyc = r_base + kk; e.name = nm; e.nlz = nlz;
    e.which = w; e.seg = s; e.frame = f;
    q.push_back(e);
  endtask

  // Expectations for cycles k0..k1 after reset release; digit i of segs is segs[8i+:8].
  task automatic push_span(input string nm, input int k0, input int k1,
                           input logic [63:0] segs0, input bit chk_nlz, input logic [63:0] segs1);
    for (int kk = k0; kk <= k1; kk++) begin
      int   w;
      logic f;
      w = (kk / 4) % 8;
      f = ((kk % 32) == 0) && (kk > 0);
      push1(nm, kk, 1'b0, w[2:0], segs0[8*w +: 8], f);
      if (chk_nlz) push1({nm, "_nlz"}, kk, 1'b1, w[2:0], segs1[8*w +: 8], f);
    end
  endtask

  task automatic wait_to(input int kk);
    while (cyc < r_base + kk) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_base = cyc;
      push1("reset", 1, 1'b0, 3'd0, 8'hC0, 1'b0);
      push1("reset_nlz", 1, 1'b1, 3'd0, 8'hC0, 1'b0);
      @(negedge clk);
    end
    rst = 1'b0;
    r_base = cyc;
  endtask

  initial begin
    data = 32'd0; dp = 8'd0; load = 1'b0; blank = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset overrides a pending load; then a mid-scan reset at digit 5.
    data = 32'h89ABCDEF; load = 1'b1;
    do_reset();
    data = 32'd0;
    push_span("s1_run", 1, 21, 64'hFFFFFFFFFFFFFFC0, 1'b0, 64'd0);
    wait_to(21);
    do_reset();
    push_span("s1_restart", 1, 4, 64'hFFFFFFFFFFFFFFC0, 1'b0, 64'd0);
    wait_to(4);

    // Full scan over two frames.
    data = 32'h89ABCDEF;
    do_reset();
    push_span("s2_scan", 1, 64, c_tab_89ab, 1'b1, c_tab_89ab);
    wait_to(64);

    // Leading-zero blanking, with and without.
    data = 32'h00000012;
    do_reset();
    push_span("s3_lz12", 1, 32, 64'hFFFFFFFFFFFFF9A4, 1'b1, 64'hC0C0C0C0C0C0F9A4);
    wait_to(32);
    data = 32'd0;
    do_reset();
    push_span("s3_lz0", 1, 32, 64'hFFFFFFFFFFFFFFC0, 1'b1, 64'hC0C0C0C0C0C0C0C0);
    wait_to(32);

    // Decimal points, including on a blanked digit.
    data = 32'h12345678; dp = 8'h04;
    do_reset();
    push_span("s4_dp2", 1, 32, 64'hF9A4B0999202F880, 1'b0, 64'd0);
    wait_to(32);
    data = 32'd0; dp = 8'h80;
    do_reset();
    push_span("s4_dp7", 1, 32, 64'h7FFFFFFFFFFFFFC0, 1'b1, 64'h40C0C0C0C0C0C0C0);
    wait_to(32);

    // Load control: hold with load=0, single-cycle load on digit 3.
    data = 32'h12345678; dp = 8'h00;
    do_reset();
    push_span("s5_pre", 1, 13, 64'hF9A4B0999282F880, 1'b0, 64'd0);
    wait_to(1);
    load = 1'b0;
    wait_to(13);
    data = 32'h12340678;
    push1("s5_load0_hold", 14, 1'b0, 3'd3, 8'h92, 1'b0);
    wait_to(14);
    load = 1'b1;
    push1("s5_load_pulse", 15, 1'b0, 3'd3, 8'hC0, 1'b0);
    wait_to(15);
    load = 1'b0; data = 32'hFFFFFFFF;
    push1("s5_after", 16, 1'b0, 3'd4, 8'h99, 1'b0);
    push1("s5_after", 17, 1'b0, 3'd4, 8'h99, 1'b0);
    wait_to(17);

    // Blank for one frame, then resume.
    data = 32'h89ABCDEF; load = 1'b1; blank = 1'b1;
    do_reset();
    push_span("s6_blank", 1, 32, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    wait_to(32);
    blank = 1'b0;
    push_span("s6_resume", 33, 40, c_tab_89ab, 1'b0, 64'd0);
    wait_to(40);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
